// File: rtl/counter_updn.sv
// counter_updn: registered up/down counter with parallel load, modulus
// MAX_VAL+1, a one-cycle terminal-event pulse and a sticky overflow flag.
// Build option: define COUNTER_UPDN_SAT_EN to saturate at the rails
// instead of wrapping. The default build (macro undefined) wraps.
module counter_updn #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1
) (
  input  logic             GCLK_Pad,
  input  logic             rst_n_Pad,
  input  logic             en_Pad,
  input  logic             dir_Pad,
  input  logic             load_Pad,
  input  logic [WIDTH-1:0] load_val_Pad,
  output logic [WIDTH-1:0] count_Pad,
  output logic             wrap_Pad,
  output logic             ovf_Pad
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;
  logic             at_top_c;
  logic             at_bot_c;
  logic             term_c;
  logic [WIDTH-1:0] load_clip_c;

  // Rail detection and load clamping.
  always_comb begin
    at_top_c    = (count_Pad == MAX);
    at_bot_c    = (count_Pad == ZERO);
    term_c      = en_Pad && (dir_Pad ? at_top_c : at_bot_c);
    load_clip_c = (load_val_Pad > MAX) ? MAX : load_val_Pad;
  end

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    count_nxt = count_Pad;
    wrap_nxt  = 1'b0;
    ovf_nxt   = ovf_Pad;
    if (load_Pad) begin
      count_nxt = load_clip_c;
      ovf_nxt   = 1'b0;
    end else if (en_Pad) begin
      if (term_c) begin
        wrap_nxt = 1'b1;
        ovf_nxt  = 1'b1;
`ifdef COUNTER_UPDN_SAT_EN
        count_nxt = dir_Pad ? MAX : ZERO;
`else
        count_nxt = dir_Pad ? ZERO : MAX;
`endif
      end else if (dir_Pad) begin
        count_nxt = count_Pad + ONE;
      end else begin
        count_nxt = count_Pad - ONE;
      end
    end
  end

  // State register with synchronous active-low reset taking top priority.
  always_ff @(posedge GCLK_Pad) begin
    if (!rst_n_Pad) begin
      count_Pad <= ZERO;
      wrap_Pad  <= 1'b0;
      ovf_Pad   <= 1'b0;
    end else begin
      count_Pad <= count_nxt;
      wrap_Pad  <= wrap_nxt;
      ovf_Pad   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updn.sv
// Directed bench for counter_updn at WIDTH=4, MAX_VAL=9. Expected values
// follow the wrap build unless COUNTER_UPDN_SAT_EN is defined.
module tb_counter_updn;

`ifdef COUNTER_UPDN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count;
  logic       wrap;
  logic       ovf;

  int n_total = 0;
  int n_bad   = 0;

  counter_updn #(.WIDTH(4), .MAX_VAL(9)) dut (
    .GCLK_Pad    (clk),
    .rst_n_Pad   (rst_n),
    .en_Pad      (en),
    .dir_Pad     (dir),
    .load_Pad    (load),
    .load_val_Pad(load_val),
    .count_Pad   (count),
    .wrap_Pad    (wrap),
    .ovf_Pad     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, then sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic d,
                      input logic l, input logic [3:0] lv);
    rst_n = r; en = e; dir = d; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input int c, input int w, input int o);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".wrap"},  int'(wrap),  w);
    chk({tag, ".ovf"},   int'(ovf),   o);
  endtask

  initial begin
    int ec;
    #2;
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk3("reset", 0, 0, 0);

    // Up count through the terminal value.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      ec = (i < 9) ? i + 1 : (SAT ? 9 : (i + 1) % 10);
      chk3($sformatf("up%0d", i), ec,
           (SAT ? (i >= 9) : (i == 9)) ? 1 : 0, (i >= 9) ? 1 : 0);
    end

    // Load above MAX_VAL clamps and clears ovf, then count down.
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
    chk3("load13", 9, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      ec = (i < 9) ? 8 - i : (SAT ? 0 : 9);
      chk3($sformatf("dn%0d", i), ec, (i == 9) ? 1 : 0, (i == 9) ? 1 : 0);
    end

    // Enable gating.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    chk3("load5", 5, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0); chk3("gate0", 6, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0); chk3("gate1", 6, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0); chk3("gate2", 7, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0); chk3("gate3", 7, 0, 0);

    // Direction change takes effect immediately.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0); chk3("dir_dn", 6, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0); chk3("dir_up", 7, 0, 0);

    // Exact-MAX and just-above loads.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd9);  chk3("load9", 9, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd10); chk3("load10", 9, 0, 0);

    // Reset coincident with a terminal event wins.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0); chk3("rst_term", 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0); chk3("rst_resume", 1, 0, 0);

    // Down-terminal from zero, then hold keeps ovf and drops wrap.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0); chk3("load0", 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0); chk3("dn_term", SAT ? 0 : 9, 1, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0); chk3("hold", SAT ? 0 : 9, 0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0); chk3("hold2", SAT ? 0 : 9, 0, 1);

    // Load beats enable and clears sticky ovf.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3); chk3("load_en", 3, 0, 0);

`ifdef COUNTER_UPDN_SAT_EN
    // Saturation at the top rail.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd8); chk3("sat_load", 8, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0); chk3("sat0", 9, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0); chk3("sat1", 9, 1, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0); chk3("sat2", 9, 1, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0); chk3("sat_dn", 8, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
